flag_bank: RTL

Parametrised status-flag register bank for the MCU datapath. It is the generalised successor of the single-bit load-enabled flag register. It holds NUM_FLAGS flags, for example C and Z. Each flag has independent load, set and clear controls. A LIFO shadow stack of SHADOW_DEPTH entries saves the flags on interrupt entry (PUSH) and restores them on return-from-interrupt (POP), which supports nested interrupts. The control unit drives all controls. The ALU drives IN.

---
 rtl/flag_bank.sv | 102 ++++++++++
 1 files changed

// File: rtl/flag_bank.sv
// Status-flag register bank with per-flag load/set/clear
// and a LIFO shadow stack for nested interrupt save/restore.
module flag_bank #(
    parameter int NUM_FLAGS    = 2,
    parameter int SHADOW_DEPTH = 2,
    localparam int CW          = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM_FLAGS-1:0] LD,
    input  logic [NUM_FLAGS-1:0] SET,
    input  logic [NUM_FLAGS-1:0] CLR,
    input  logic [NUM_FLAGS-1:0] IN,
    input  logic                 PUSH,
    input  logic                 POP,
    output logic [NUM_FLAGS-1:0] OUT,
    output logic [CW-1:0]        COUNT,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic                 OVF_ERR,
    output logic                 UNF_ERR
);

    logic [NUM_FLAGS-1:0] out_q, out_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [NUM_FLAGS-1:0] stack_q [SHADOW_DEPTH];
    logic [NUM_FLAGS-1:0] stack_d [SHADOW_DEPTH];

    logic                 full, empty;
    logic                 push_only, pop_only;
    logic                 push_ok, pop_ok;
    logic [NUM_FLAGS-1:0] top;
    logic [NUM_FLAGS-1:0] flag_upd;

    assign full      = (count_q == CW'(SHADOW_DEPTH));
    assign empty     = (count_q == '0);
    assign push_only = PUSH && !POP;
    assign pop_only  = POP && !PUSH;
    assign push_ok   = push_only && !full;
    assign pop_ok    = pop_only && !empty;

    always_comb begin
        top = '0;
        for (int i = 0; i < SHADOW_DEPTH; i++) begin
            if (CW'(i) == count_q - CW'(1)) top = stack_q[i];
        end
    end

    always_comb begin
        flag_upd = out_q;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (CLR[i])      flag_upd[i] = 1'b0;
            else if (SET[i]) flag_upd[i] = 1'b1;
            else if (LD[i])  flag_upd[i] = IN[i];
        end
    end

    always_comb begin
        out_d   = pop_ok ? top : flag_upd;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        for (int i = 0; i < SHADOW_DEPTH; i++) stack_d[i] = stack_q[i];

        // the saved value is the pre-update flags of this cycle
        if (push_ok) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) begin
                if (CW'(i) == count_q) stack_d[i] = out_q;
            end
            count_d = count_q + CW'(1);
        end
        if (push_only && full) ovf_d = 1'b1;
        if (pop_ok) count_d = count_q - CW'(1);
        if (pop_only && empty) unf_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            out_q   <= out_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int i = 0; i < SHADOW_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

    assign OUT     = out_q;
    assign COUNT   = count_q;
    assign FULL    = full;
    assign EMPTY   = empty;
    assign OVF_ERR = ovf_q;
    assign UNF_ERR = unf_q;

endmodule
